// File: rtl/axil_master_pkg.sv
// ---------------------------------------------------------------------------
// axil_master_pkg
// Shared types and constants for the AXI4-Lite master bridge.
//   state_t      : bridge FSM states
//   RESP_*       : AXI response codes
// ---------------------------------------------------------------------------
package axil_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_master_timer.sv
// ---------------------------------------------------------------------------
// axil_master_timer
// Saturating up-counter used as the response watchdog of the bridge.
// Ports:
//   i_clk      clock
//   i_reset    synchronous active-high reset
//   i_clear    restart the count at zero
//   i_enable   count this cycle
//   o_expired  count has reached C_LIMIT (stays high until cleared)
// ---------------------------------------------------------------------------
module axil_master_timer #(
  parameter int unsigned C_LIMIT = 14
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned W = (C_LIMIT < 1) ? 1 : $clog2(C_LIMIT + 1);
  localparam logic [W-1:0] LIMIT = W'(C_LIMIT);

  logic [W-1:0] r_count;

  // Count enabled cycles, holding at the limit so the flag cannot wrap away.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/axil_master_bridge.sv
// ---------------------------------------------------------------------------
// axil_master_bridge
// AXI4-Lite initiator: one single-beat read or write command from the core
// becomes one AXI4-Lite transaction; the bus response is returned to the core.
// One transaction outstanding at a time. All bus outputs are registered.
// Ports:
//   M_AXI_ACLK / M_AXI_ARESET     clock, synchronous active-high reset
//   cmd_*                         core command (valid/ready, write, addr, data, strobe)
//   rsp_*                         core response (valid/ready, rdata, resp, timeout)
//   M_AXI_AW*/W*/B*/AR*/R*        AXI4-Lite master channels
// Build option:
//   AXIL_MASTER_TIMEOUT_EN        adds a watchdog that answers the core with
//                                 DECERR + rsp_timeout after C_TIMEOUT_CYCLES
//                                 (must be >= 3) while the bus still completes.
// ---------------------------------------------------------------------------
module axil_master_bridge
  import axil_master_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  state_t          r_state, w_state_next;
  logic            r_cmd_ready, w_cmd_ready_n;
  logic [AW-1:0]   r_addr, w_addr_n;
  logic [DW-1:0]   r_wdata, w_wdata_n;
  logic [SW-1:0]   r_wstrb, w_wstrb_n;
  logic            r_awvalid, w_awvalid_n;
  logic            r_wvalid, w_wvalid_n;
  logic            r_aw_done, w_aw_done_n;
  logic            r_w_done, w_w_done_n;
  logic            r_bready, w_bready_n;
  logic            r_arvalid, w_arvalid_n;
  logic            r_rready, w_rready_n;
  logic            r_rsp_valid, w_rsp_valid_n;
  logic [DW-1:0]   r_rsp_rdata, w_rsp_rdata_n;
  logic [1:0]      r_rsp_resp, w_rsp_resp_n;
  logic            r_rsp_timeout, w_rsp_timeout_n;
  logic            r_timed_out, w_timed_out_n;

  logic w_accept, w_busy;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  // The registered ready is 1 out of reset; gating with the reset input keeps
  // it low while reset is held and high from the first cycle afterwards.
  assign cmd_ready = r_cmd_ready & ~M_AXI_ARESET;
  assign w_accept  = (r_state == ST_IDLE) && r_cmd_ready && cmd_valid;
  assign w_busy    = (r_state == ST_WR_REQ) || (r_state == ST_WR_RESP) ||
                     (r_state == ST_RD_REQ) || (r_state == ST_RD_RESP);

  assign w_aw_hs = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs  = r_wvalid  & M_AXI_WREADY;
  assign w_b_hs  = r_bready  & M_AXI_BVALID;
  assign w_ar_hs = r_arvalid & M_AXI_ARREADY;
  assign w_r_hs  = r_rready  & M_AXI_RVALID;

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic w_expired;

  // The count reads 0 in the first busy cycle and the response register adds
  // one more, so flagging at C_TIMEOUT_CYCLES-2 puts rsp_valid exactly
  // C_TIMEOUT_CYCLES cycles after the command was accepted.
  axil_master_timer #(
    .C_LIMIT (C_TIMEOUT_CYCLES - 2)
  ) u_timer (
    .i_clk     (M_AXI_ACLK),
    .i_reset   (M_AXI_ARESET),
    .i_clear   (w_accept),
    .i_enable  (w_busy),
    .o_expired (w_expired)
  );
`endif

  // Next-state and next-output logic. Every bus and core output is a register,
  // so this block decides what each register holds in the following cycle.
  always_comb begin
    w_state_next    = r_state;
    w_cmd_ready_n   = r_cmd_ready;
    w_addr_n        = r_addr;
    w_wdata_n       = r_wdata;
    w_wstrb_n       = r_wstrb;
    w_awvalid_n     = r_awvalid;
    w_wvalid_n      = r_wvalid;
    w_aw_done_n     = r_aw_done;
    w_w_done_n      = r_w_done;
    w_bready_n      = r_bready;
    w_arvalid_n     = r_arvalid;
    w_rready_n      = r_rready;
    w_rsp_valid_n   = r_rsp_valid;
    w_rsp_rdata_n   = r_rsp_rdata;
    w_rsp_resp_n    = r_rsp_resp;
    w_rsp_timeout_n = r_rsp_timeout;
    w_timed_out_n   = r_timed_out;

    case (r_state)
      ST_IDLE: begin
        w_cmd_ready_n = 1'b1;
        if (w_accept) begin
          w_cmd_ready_n = 1'b0;
          w_addr_n      = cmd_addr;
          w_wdata_n     = cmd_wdata;
          w_wstrb_n     = cmd_wstrb;
          w_timed_out_n = 1'b0;
          if (cmd_write) begin
            w_state_next = ST_WR_REQ;
            w_awvalid_n  = 1'b1;
            w_wvalid_n   = 1'b1;
            w_aw_done_n  = 1'b0;
            w_w_done_n   = 1'b0;
          end else begin
            w_state_next = ST_RD_REQ;
            w_arvalid_n  = 1'b1;
          end
        end
      end
      ST_WR_REQ: begin
        if (w_aw_hs) begin
          w_awvalid_n = 1'b0;
          w_aw_done_n = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid_n = 1'b0;
          w_w_done_n = 1'b1;
        end
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_next = ST_WR_RESP;
          w_bready_n   = 1'b1;
          w_aw_done_n  = 1'b0;
          w_w_done_n   = 1'b0;
        end
      end
      ST_WR_RESP: begin
        if (w_b_hs) begin
          w_bready_n = 1'b0;
          if (!r_timed_out) begin
            w_state_next    = ST_RSP;
            w_rsp_valid_n   = 1'b1;
            w_rsp_rdata_n   = '0;
            w_rsp_resp_n    = M_AXI_BRESP;
            w_rsp_timeout_n = 1'b0;
          end else if (r_rsp_valid && !rsp_ready) begin
            w_state_next = ST_RSP;
          end else begin
            w_state_next  = ST_IDLE;
            w_cmd_ready_n = 1'b1;
          end
        end
      end
      ST_RD_REQ: begin
        if (w_ar_hs) begin
          w_arvalid_n  = 1'b0;
          w_rready_n   = 1'b1;
          w_state_next = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (w_r_hs) begin
          w_rready_n = 1'b0;
          if (!r_timed_out) begin
            w_state_next    = ST_RSP;
            w_rsp_valid_n   = 1'b1;
            w_rsp_rdata_n   = M_AXI_RDATA;
            w_rsp_resp_n    = M_AXI_RRESP;
            w_rsp_timeout_n = 1'b0;
          end else if (r_rsp_valid && !rsp_ready) begin
            w_state_next = ST_RSP;
          end else begin
            w_state_next  = ST_IDLE;
            w_cmd_ready_n = 1'b1;
          end
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          w_state_next    = ST_IDLE;
          w_cmd_ready_n   = 1'b1;
          w_rsp_valid_n   = 1'b0;
          w_rsp_rdata_n   = '0;
          w_rsp_resp_n    = RESP_OKAY;
          w_rsp_timeout_n = 1'b0;
          w_timed_out_n   = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // A timeout response may be taken by the core while the bus is still busy.
    if (w_busy && r_rsp_valid && rsp_ready) begin
      w_rsp_valid_n   = 1'b0;
      w_rsp_rdata_n   = '0;
      w_rsp_resp_n    = RESP_OKAY;
      w_rsp_timeout_n = 1'b0;
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    // A final bus handshake in the same cycle beats the watchdog.
    if (w_busy && w_expired && !r_timed_out && !w_b_hs && !w_r_hs) begin
      w_rsp_valid_n   = 1'b1;
      w_rsp_rdata_n   = '0;
      w_rsp_resp_n    = RESP_DECERR;
      w_rsp_timeout_n = 1'b1;
      w_timed_out_n   = 1'b1;
    end
`endif
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b1;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= RESP_OKAY;
      r_rsp_timeout <= 1'b0;
      r_timed_out   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cmd_ready   <= w_cmd_ready_n;
      r_addr        <= w_addr_n;
      r_wdata       <= w_wdata_n;
      r_wstrb       <= w_wstrb_n;
      r_awvalid     <= w_awvalid_n;
      r_wvalid      <= w_wvalid_n;
      r_aw_done     <= w_aw_done_n;
      r_w_done      <= w_w_done_n;
      r_bready      <= w_bready_n;
      r_arvalid     <= w_arvalid_n;
      r_rready      <= w_rready_n;
      r_rsp_valid   <= w_rsp_valid_n;
      r_rsp_rdata   <= w_rsp_rdata_n;
      r_rsp_resp    <= w_rsp_resp_n;
      r_rsp_timeout <= w_rsp_timeout_n;
      r_timed_out   <= w_timed_out_n;
    end
  end

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;

`ifdef AXIL_MASTER_TIMEOUT_EN
  assign rsp_timeout = r_rsp_timeout;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule
